// File: rtl/mux_rr_arbiter_if.sv
// Bus between the four sources / downstream consumer and the round-robin arbiter.
// master: the sources and consumer side; slave: the arbiter.
interface mux_rr_arbiter_if #(
    parameter int unsigned W = 2
) ();
    logic [3:0]     req;
    logic [4*W-1:0] x;
    logic           out_ready;
    logic [3:0]     gnt;
    logic [1:0]     sel;
    logic [W-1:0]   f;
    logic           f_valid;
    logic           busy;

    modport master (
        output req, x, out_ready,
        input  gnt, sel, f, f_valid, busy
    );

    modport slave (
        input  req, x, out_ready,
        output gnt, sel, f, f_valid, busy
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of a 4:1 mux-with-default (default value 0).
// Grants one of four requesters, drives the shared output f from its data, and
// reports f_valid/busy. A grant is kept while the owner holds req; on release the
// next requester is picked on the same edge with no idle bubble.
// Optional feature macro: ARB_HOLD_LIMIT_EN -- rotate the grant after HOLD_MAX
// beats if another requester is pending.
module mux_rr_arbiter #(
    parameter int unsigned W        = 2,
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mux_rr_arbiter_if.slave     bus_io
);

    if (HOLD_MAX < 1) begin : g_bad_hold_max
        $error("HOLD_MAX must be at least 1");
    end

    typedef enum logic {
        StIdle,
        StGrant
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] gnt_q,   gnt_d;
    logic [1:0] sel_q,   sel_d;
    logic [1:0] last_q,  last_d;

    logic [2:0] pick;  // {found, index}
    logic       take;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int unsigned CntW = $clog2(HOLD_MAX + 1);
    localparam logic [CntW-1:0] LimitM1 = CntW'(HOLD_MAX - 1);
    localparam logic [CntW-1:0] LimitMax = CntW'(HOLD_MAX);

    logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
    logic            beat;
`endif

    // First asserted request scanning last+1, last+2, ... (mod 4).
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (r[idx] && !res[2]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Next-state logic: grant selection, release handling and optional hold limit.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        take    = 1'b0;
        // Masking the current owner makes this the "other requesters" pick in
        // StGrant; in StIdle gnt_q is zero so it is the plain pick.
        pick    = rr_pick(bus_io.req & ~gnt_q, last_q);
`ifdef ARB_HOLD_LIMIT_EN
        beat_cnt_d = beat_cnt_q;
        beat       = (state_q == StGrant) && bus_io.req[sel_q] && bus_io.out_ready;
`endif

        unique case (state_q)
            StIdle: begin
                take = pick[2];
            end
            StGrant: begin
                if (!bus_io.req[sel_q]) begin
                    take = pick[2];
                    if (!pick[2]) begin
                        state_d = StIdle;
                        gnt_d   = 4'b0000;
                    end
                end
`ifdef ARB_HOLD_LIMIT_EN
                else if (beat) begin
                    if (beat_cnt_q == LimitM1) begin
                        beat_cnt_d = '0;
                        take       = pick[2];
                    end else if (beat_cnt_q != LimitMax) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (take) begin
            state_d = StGrant;
            gnt_d   = 4'b0001 << pick[1:0];
            sel_d   = pick[1:0];
            last_d  = pick[1:0];
        end
`ifdef ARB_HOLD_LIMIT_EN
        if (take || state_d == StIdle) begin
            beat_cnt_d = '0;
        end
`endif
    end

    // State registers; last resets to 3 so source 0 has first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    // Beat counter for the current grant; cleared on every grant change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`endif

    // Shared datapath: 4:1 mux keyed by sel, default 0 when no grant is held.
    always_comb begin
        bus_io.f = '0;
        if (state_q == StGrant) begin
            unique case (sel_q)
                2'd0: bus_io.f = bus_io.x[W-1:0];
                2'd1: bus_io.f = bus_io.x[2*W-1:W];
                2'd2: bus_io.f = bus_io.x[3*W-1:2*W];
                2'd3: bus_io.f = bus_io.x[4*W-1:3*W];
                default: bus_io.f = '0;
            endcase
        end
    end

    assign bus_io.gnt     = gnt_q;
    assign bus_io.sel     = sel_q;
    assign bus_io.busy    = (state_q == StGrant);
    assign bus_io.f_valid = (state_q == StGrant) && bus_io.req[sel_q];

endmodule
